// File: rtl/mem_unit_pkg.sv
// Shared definitions for the load/store unit, reservation station and ALU:
// opcodes, the no-request code, the default rename tag width and op decoding.
package mem_unit_pkg;

  localparam int TAG_W = 3;

  localparam logic [4:0] OP_NOP = 5'b11111;
  localparam logic [4:0] OP_ADD = 5'b00001;
  localparam logic [4:0] OP_LB  = 5'b10010;
  localparam logic [4:0] OP_LH  = 5'b10011;
  localparam logic [4:0] OP_LW  = 5'b10100;
  localparam logic [4:0] OP_LBU = 5'b10101;
  localparam logic [4:0] OP_LHU = 5'b10110;
  localparam logic [4:0] OP_SB  = 5'b10111;
  localparam logic [4:0] OP_SH  = 5'b11000;
  localparam logic [4:0] OP_SW  = 5'b11001;

  // last_k is the index of the final byte touched (n-1)
  typedef struct packed {
    logic       is_mem;
    logic       is_store;
    logic [1:0] last_k;
  } req_info_t;

  function automatic req_info_t decode_op(input logic [4:0] op);
    req_info_t r;
    r = '{is_mem: 1'b0, is_store: 1'b0, last_k: 2'd0};
    case (op)
      OP_LB, OP_LBU: r = '{is_mem: 1'b1, is_store: 1'b0, last_k: 2'd0};
      OP_LH, OP_LHU: r = '{is_mem: 1'b1, is_store: 1'b0, last_k: 2'd1};
      OP_LW:         r = '{is_mem: 1'b1, is_store: 1'b0, last_k: 2'd3};
      OP_SB:         r = '{is_mem: 1'b1, is_store: 1'b1, last_k: 2'd0};
      OP_SH:         r = '{is_mem: 1'b1, is_store: 1'b1, last_k: 2'd1};
      OP_SW:         r = '{is_mem: 1'b1, is_store: 1'b1, last_k: 2'd3};
      default:       r = '{is_mem: 1'b0, is_store: 1'b0, last_k: 2'd0};
    endcase
    return r;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] w, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = w;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      2'd3:    r[31:24] = b;
      default: r = w;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_unit_load_extend.sv
// Sign/zero extension of an assembled little-endian load value according to the load opcode.
module load_extend
  import mem_unit_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  // Select the extension form for the load width
  always_comb begin
    result = raw;
    case (op)
      OP_LB:   result = {{24{raw[7]}}, raw[7:0]};
      OP_LH:   result = {{16{raw[15]}}, raw[15:0]};
      OP_LBU:  result = {24'd0, raw[7:0]};
      OP_LHU:  result = {16'd0, raw[15:0]};
      OP_LW:   result = raw;
      default: result = raw;
    endcase
  end

endmodule

// File: rtl/mem_unit.sv
// Byte-serial load/store unit: walks n bytes over an 8-bit memory port and
// broadcasts the (extended) result with its rename tag for one cycle.
module mem_unit #(
  parameter int TAG_W = mem_unit_pkg::TAG_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       op,
  input  logic [31:0]      value1,
  input  logic [31:0]      value2,
  input  logic [31:0]      imm,
  input  logic [TAG_W-1:0] des,
  output logic             busy,
  output logic [31:0]      mem_a,
  output logic [7:0]       mem_dout,
  output logic             mem_wr,
  input  logic [7:0]       mem_din,
  output logic [31:0]      result_data,
  output logic [TAG_W-1:0] result_des
);

  import mem_unit_pkg::*;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]       state_r;
  logic [1:0]       cnt_r;
  logic [1:0]       last_r;
  logic             is_store_r;
  logic [4:0]       op_r;
  logic [TAG_W-1:0] des_r;
  logic [31:0]      addr_r;
  logic [31:0]      sdata_r;
  logic [31:0]      asm_r;

  req_info_t        info_s;
  logic [1:0]       cnt_next_s;
  logic [31:0]      raw_s;
  logic [31:0]      ext_s;

  // Request decode and the final load word with the last byte merged straight from the port
  always_comb begin
    info_s     = decode_op(op);
    cnt_next_s = cnt_r + 2'd1;
    raw_s      = put_byte(asm_r, last_r, mem_din);
  end

  load_extend u_load_extend (
    .op     (op_r),
    .raw    (raw_s),
    .result (ext_s)
  );

  // Control FSM, memory port and broadcast registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 2'd0;
      last_r      <= 2'd0;
      is_store_r  <= 1'b0;
      op_r        <= OP_NOP;
      des_r       <= '0;
      addr_r      <= 32'd0;
      sdata_r     <= 32'd0;
      asm_r       <= 32'd0;
      busy        <= 1'b0;
      mem_a       <= 32'd0;
      mem_dout    <= 8'd0;
      mem_wr      <= 1'b0;
      result_data <= 32'd0;
      result_des  <= '0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (info_s.is_mem) begin
            state_r    <= ST_ACCESS;
            cnt_r      <= 2'd0;
            last_r     <= info_s.last_k;
            is_store_r <= info_s.is_store;
            op_r       <= op;
            des_r      <= des;
            addr_r     <= value1 + imm;
            sdata_r    <= {8'd0, value2[31:8]};
            asm_r      <= 32'd0;
            busy       <= 1'b1;
            mem_a      <= value1 + imm;
            mem_dout   <= value2[7:0];
            mem_wr     <= info_s.is_store;
          end
        end
        ST_ACCESS: begin
          // Byte k-1 appears on mem_din during access cycle k
          if (!is_store_r && (cnt_r != 2'd0)) begin
            asm_r <= put_byte(asm_r, cnt_r - 2'd1, mem_din);
          end
          if (cnt_r == last_r) begin
            mem_wr <= 1'b0;
            if (is_store_r) begin
              state_r     <= ST_DONE;
              result_data <= 32'd0;
              result_des  <= des_r;
            end else begin
              state_r <= ST_WAIT;
            end
          end else begin
            cnt_r    <= cnt_next_s;
            mem_a    <= addr_r + {30'd0, cnt_next_s};
            mem_dout <= sdata_r[7:0];
            sdata_r  <= {8'd0, sdata_r[31:8]};
          end
        end
        ST_WAIT: begin
          state_r     <= ST_DONE;
          asm_r       <= raw_s;
          result_data <= ext_s;
          result_des  <= des_r;
        end
        ST_DONE: begin
          state_r    <= ST_IDLE;
          busy       <= 1'b0;
          result_des <= '0;
        end
        default: begin
          state_r    <= ST_IDLE;
          busy       <= 1'b0;
          mem_wr     <= 1'b0;
          result_des <= '0;
        end
      endcase
    end
  end

endmodule
